// File: rtl/psp_pkg.sv
// psp_pkg: shared constants and types for the psp memory front-end.
//   DONE_ADDR / LED_ADDR / CYCLE_ADDR : default MMIO window addresses
//   EXIT_TIMEOUT                      : exit code reported by the watchdog
//   mmio_sel_e                        : decode result for a granted address
package psp_pkg;

  localparam logic [31:0] DONE_ADDR    = 32'h600d_600d;
  localparam logic [31:0] LED_ADDR     = 32'h600d_6000;
  localparam logic [31:0] CYCLE_ADDR   = 32'h600d_6004;
  localparam logic [31:0] EXIT_TIMEOUT = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    DONE  = 2'd1,
    LED   = 2'd2,
    CYCLE = 2'd3
  } mmio_sel_e;

endpackage

// File: rtl/psp_mem_arbiter_rr.sv
// rr_arbiter: round-robin one-hot arbiter.
//   clk, reset_n : clock, async active-low reset
//   req[N]       : per-port request
//   advance      : enable; when low no grant is issued and prio holds
//   gnt[N]       : one-hot grant, combinational from req
// prio points at the port with highest priority; after a grant to port i
// it moves to (i+1) mod N.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] prio_q, prio_d;

  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    gnt    = '0;
    prio_d = prio_q;
    for (int k = 0; k < N; k++) begin
      idx = (int'(prio_q) + k) % N;
      if (!found && advance && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        prio_d   = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prio_q <= '0;
    else          prio_q <= prio_d;
  end

endmodule

// File: rtl/psp_mem_arbiter.sv
// psp_mem_arbiter: round-robin front-end of NUM_PORTS requesters onto one
// synchronous single-port memory, plus a small MMIO window (exit/done,
// LED, cycle counter) and an optional watchdog.
//   clk, reset_n           : clock, async active-low reset
//   req/we/addr/wdata      : per-port request, held until gnt
//   gnt                    : one-hot grant (combinational, request cycle)
//   rvalid, rdata          : one-hot response pulse next cycle, shared data
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata : memory side (1-cycle read)
//   led                    : LED register
//   done, exit_code        : sticky exit flag and its code
module psp_mem_arbiter
  import psp_pkg::*;
#(
  parameter int                NUM_PORTS      = 2,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] DONE_ADDR      = ADDR_W'(psp_pkg::DONE_ADDR),
  parameter logic [ADDR_W-1:0] LED_ADDR       = ADDR_W'(psp_pkg::LED_ADDR),
  parameter logic [ADDR_W-1:0] CYCLE_ADDR     = ADDR_W'(psp_pkg::CYCLE_ADDR),
  parameter int                TIMEOUT_CYCLES = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              we,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata,
  output logic [NUM_PORTS-1:0]              gnt,
  output logic [NUM_PORTS-1:0]              rvalid,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic [3:0]                        led,
  output logic                              done,
  output logic [DATA_W-1:0]                 exit_code
);

  // Grants are masked while reset is held so gnt reads 0 during reset.
  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .advance (reset_n),
    .gnt     (gnt)
  );

  // Granted request (gnt is one-hot, so OR-muxing is exact)
  logic              any_gnt, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  mmio_sel_e         sel;

  always_comb begin
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        g_we    = g_we    | we[i];
        g_addr  = g_addr  | addr[i];
        g_wdata = g_wdata | wdata[i];
      end
    end
    any_gnt = |gnt;
    if      (g_addr == DONE_ADDR)  sel = DONE;
    else if (g_addr == LED_ADDR)   sel = LED;
    else if (g_addr == CYCLE_ADDR) sel = CYCLE;
    else                           sel = NONE;
  end

  // State
  logic [DATA_W-1:0]    cyc_q, cyc_d;
  logic [3:0]           led_q, led_d;
  logic                 done_q, done_d;
  logic [DATA_W-1:0]    exit_code_q, exit_code_d;
  logic [NUM_PORTS-1:0] resp_port_q, resp_port_d;
  logic                 resp_is_mmio_q, resp_is_mmio_d;
  logic [DATA_W-1:0]    resp_mmio_data_q, resp_mmio_data_d;

  always_comb begin
    cyc_d       = cyc_q + 1'b1;
    led_d       = led_q;
    done_d      = done_q;
    exit_code_d = exit_code_q;

    if (any_gnt && g_we && sel == LED) led_d = g_wdata[3:0];

    // Exit write has priority over the watchdog; both frozen once done.
    if (!done_q) begin
      if (any_gnt && g_we && sel == DONE) begin
        done_d      = 1'b1;
        exit_code_d = g_wdata;
      end else if (TIMEOUT_CYCLES != 0 &&
                   cyc_q == DATA_W'(TIMEOUT_CYCLES - 1)) begin
        done_d      = 1'b1;
        exit_code_d = DATA_W'(EXIT_TIMEOUT);
      end
    end

    // Writes of any kind answer 0 through the MMIO data path, so only
    // memory reads take rdata from mem_rdata.
    resp_port_d      = gnt;
    resp_is_mmio_d   = any_gnt && (sel != NONE || g_we);
    resp_mmio_data_d = '0;
    if (any_gnt && !g_we) begin
      case (sel)
        DONE:    resp_mmio_data_d = exit_code_q;
        LED:     resp_mmio_data_d = DATA_W'(led_q);
        CYCLE:   resp_mmio_data_d = cyc_q;
        default: resp_mmio_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q            <= '0;
      led_q            <= '0;
      done_q           <= 1'b0;
      exit_code_q      <= '0;
      resp_port_q      <= '0;
      resp_is_mmio_q   <= 1'b0;
      resp_mmio_data_q <= '0;
    end else begin
      cyc_q            <= cyc_d;
      led_q            <= led_d;
      done_q           <= done_d;
      exit_code_q      <= exit_code_d;
      resp_port_q      <= resp_port_d;
      resp_is_mmio_q   <= resp_is_mmio_d;
      resp_mmio_data_q <= resp_mmio_data_d;
    end
  end

  // Memory strobes; writes are blocked after the program has exited.
  assign mem_en    = any_gnt && sel == NONE;
  assign mem_we    = mem_en && g_we && !done_q;
  assign mem_addr  = g_addr;
  assign mem_wdata = g_wdata;

  assign rvalid    = resp_port_q;
  assign rdata     = !(|resp_port_q) ? '0 :
                     resp_is_mmio_q  ? resp_mmio_data_q : mem_rdata;
  assign led       = led_q;
  assign done      = done_q;
  assign exit_code = exit_code_q;

endmodule

// File: doc/psp_mem_arbiter.md
# psp_mem_arbiter

Parametrised memory front-end for the psp top level. It arbitrates NUM_PORTS requesters (imem, dmem, and later cache refill ports) round-robin onto one synchronous single-port main memory. It decodes a small MMIO window: the exit/done register at 0x600d600d, an LED register, and a cycle counter. A watchdog forces `done` if the program never exits.

## Interface
Parameters:
- NUM_PORTS, 2, number of requester ports (≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data width (≥32)
- DONE_ADDR, 32'h600d600d, write here ends simulation
- LED_ADDR, 32'h600d6000, LED register
- CYCLE_ADDR, 32'h600d6004, free-running cycle counter (read-only, low DATA_W bits)
- TIMEOUT_CYCLES, 0, watchdog limit; 0 disables

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_PORTS  per-port request
- we  in  NUM_PORTS  per-port write enable
- addr  in  NUM_PORTS×ADDR_W  per-port address
- wdata  in  NUM_PORTS×DATA_W  per-port write data
- gnt  out  NUM_PORTS  one-hot grant pulse
- rvalid  out  NUM_PORTS  one-hot response pulse
- rdata  out  DATA_W  response data, shared by all ports
- mem_en, mem_we  out  1  memory strobes
- mem_addr  out  ADDR_W, mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  valid one cycle after mem_en
- led  out  4  LED register
- done  out  1  sticky exit flag
- exit_code  out  DATA_W  value written to DONE_ADDR, or timeout code

## Operation
- Arbitration: round-robin with pointer `prio`, reset 0. Grant the first requesting port at or after `prio` (mod NUM_PORTS). After granting port i, `prio` becomes (i+1) mod NUM_PORTS. `gnt` is combinational in the request cycle, with at most one grant per cycle.
- Handshake: the requester holds req/we/addr/wdata stable until `gnt`. Every grant produces exactly one `rvalid` pulse to the same port on the next cycle. Reads return data on `rdata`; writes return 0.
- Decode of the granted address:
  - MMIO hit: no mem_en.
  - DONE_ADDR write: done←1, exit_code←wdata.
  - DONE_ADDR read: returns exit_code.
  - LED_ADDR write: led←wdata[3:0].
  - LED_ADDR read: returns zero-extended led.
  - CYCLE_ADDR: writes are ignored.
  - Otherwise: drive mem_en=1, mem_we=we, mem_addr, mem_wdata.
- After done=1: mem_we is forced to 0. Grants, reads and responses continue. done and exit_code never change again until reset.
- Cycle counter: increments every cycle from 0 and wraps at 2^DATA_W.
- Watchdog: when TIMEOUT_CYCLES≠0, done=0, and the counter reaches TIMEOUT_CYCLES−1, set done=1 and exit_code=32'hDEAD_DEAD (zero-extended).
- Simultaneous events: a DONE_ADDR write and the watchdog trip in the same cycle → the write wins.
- Reset values: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, led=0, done=0, exit_code=0, prio=0, counter=0.

## Timing
- Cycle N: req high and selected → gnt[i]=1, memory/MMIO strobes driven, MMIO registers update at the end of N.
- Cycle N+1: rvalid[i]=1. rdata is mem_rdata for memory reads, the registered MMIO value for MMIO reads, 0 for writes.
- Throughput: one grant per cycle, back-to-back, no bubbles.
- Read-after-write: a same-address read issued the cycle after a write sees the new data (memory write-first, MMIO registered).
- done rises in the cycle after the DONE_ADDR grant, or after the watchdog terminal count.
- reset_n low mid-transaction: all outputs go to their reset values immediately. A pending response is dropped and no rvalid is issued after reset.
- Response-side pipeline registers: `resp_port` (one-hot), `resp_is_mmio`, `resp_mmio_data`.

## Structure
- `psp_pkg` holds:
  - MMIO address constants (DONE_ADDR, LED_ADDR, CYCLE_ADDR)
  - EXIT_TIMEOUT = 32'hDEAD_DEAD
  - `mmio_sel_e` enum: NONE, DONE, LED, CYCLE
- Sub-module `rr_arbiter #(N)`: req, advance → one-hot gnt, owns `prio`.
- The top module holds the decode, MMIO registers, watchdog and response pipeline.
- psp instantiates it with NUM_PORTS=2: port 0 = imem, port 1 = dmem.

## Test plan
- Reset: hold reset_n=0 with req=2'b11 → gnt=0, mem_en=0, done=0, led=0. Release → port 0 granted first.
- Fairness: req=2'b11 held for 6 cycles → gnt sequence 01,10,01,10,01,10. Each gnt is followed next cycle by the matching rvalid.
- Memory round trip: port 1 writes 0x1234_5678 to 0x100, next cycle port 0 reads 0x100 → rvalid[0] with rdata=0x1234_5678.
- MMIO: write 0xF to LED_ADDR → led=4'hF, no mem_en. Read LED_ADDR → rdata=0xF. Read CYCLE_ADDR twice, 3 cycles apart → values differ by 3.
- Exit: write 0x2A to DONE_ADDR → done=1 and exit_code=0x2A next cycle. A later memory write produces rvalid but mem_we stays 0. A second DONE write leaves exit_code=0x2A.
- Watchdog: TIMEOUT_CYCLES=20, no requests → done rises at cycle 20, exit_code=0xDEAD_DEAD. Assert reset_n=0 mid-run → done=0 immediately.
